// File: rtl/mouse_ctrl_pkg.sv
// Shared types and helpers for the per-frame mouse sampling controller.
package mouse_ctrl_pkg;

  localparam int unsigned POS_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CLAMP,
    STEP,
    PRESENT
  } state_e;

  // Widened signed compares keep the bounds check free of constant-folded unsigned compares.
  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] x,
                                                 input logic [POS_W-1:0] lo,
                                                 input logic [POS_W-1:0] hi);
    logic signed [POS_W+1:0] xs;
    logic signed [POS_W+1:0] los;
    logic signed [POS_W+1:0] his;
    xs  = $signed({2'b00, x});
    los = $signed({2'b00, lo});
    his = $signed({2'b00, hi});
    if (xs < los) begin
      return lo;
    end else if (xs > his) begin
      return hi;
    end
    return x;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debounces a raw button level: a new level is accepted after DEB_CYCLES consecutive
// cycles of disagreement; rise_pulse marks the cycle the accepted level turned to 1.
module button_debouncer #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic pclk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (raw != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = raw;
        rise_d  = raw;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/mouse_sample_ctrl.sv
// Per-frame mouse sampler: captures x and click once per frame, clamps and rate-limits x,
// and hands one sample per frame to game logic over valid/ready.
module mouse_sample_ctrl
  import mouse_ctrl_pkg::*;
#(
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 400,
  parameter int unsigned X_INIT     = 100,
  parameter int unsigned MAX_STEP   = 16,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             mouse_left,
  input  logic [POS_W-1:0] mouse_xpos,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [POS_W-1:0] player_x,
  output logic             jump_req,
  output logic             overrun
);

  localparam logic [POS_W-1:0]        X_MIN_V  = POS_W'(X_MIN);
  localparam logic [POS_W-1:0]        X_MAX_V  = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]        X_INIT_V = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]        STEP_V   = POS_W'(MAX_STEP);
  localparam logic signed [POS_W:0]   STEP_S   = (POS_W + 1)'(MAX_STEP);

  state_e           state_q, state_d;
  logic [POS_W-1:0] x_raw_q, x_raw_d;
  logic [POS_W-1:0] x_clamp_q, x_clamp_d;
  logic             x_jump_q, x_jump_d;
  logic [POS_W-1:0] player_x_q, player_x_d;
  logic             jump_q, jump_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             pending_q, pending_d;
  logic             pend_clr;
  logic             btn_level, btn_rise;
  logic signed [POS_W:0] delta;
  logic [POS_W-1:0] x_step;

  button_debouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .pclk      (pclk),
    .rst       (rst),
    .raw       (mouse_left),
    .level     (btn_level),
    .rise_pulse(btn_rise)
  );

  // Rate limiter: move at most MAX_STEP toward the clamped target.
  always_comb begin
    delta = $signed({1'b0, x_clamp_q}) - $signed({1'b0, player_x_q});
    if (delta > STEP_S) begin
      x_step = player_x_q + STEP_V;
    end else if (delta < -STEP_S) begin
      x_step = player_x_q - STEP_V;
    end else begin
      x_step = x_clamp_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_raw_d    = x_raw_q;
    x_clamp_d  = x_clamp_q;
    x_jump_d   = x_jump_q;
    player_x_d = player_x_q;
    jump_d     = jump_q;
    valid_d    = valid_q;
    pend_clr   = 1'b0;
    overrun_d  = frame_tick && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (frame_tick) state_d = CAPTURE;
      end
      CAPTURE: begin
        x_raw_d  = mouse_xpos;
        x_jump_d = pending_q;
        state_d  = CLAMP;
      end
      CLAMP: begin
        x_clamp_d = clamp_pos(x_raw_q, X_MIN_V, X_MAX_V);
        state_d   = STEP;
      end
      STEP: begin
        player_x_d = x_step;
        jump_d     = x_jump_q;
        valid_d    = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (valid_q && out_ready) begin
          valid_d  = 1'b0;
          jump_d   = 1'b0;
          pend_clr = x_jump_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A click landing on the acceptance edge belongs to the next sample, so set wins.
    pending_d = (pending_q & ~pend_clr) | (btn_rise & btn_level);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_raw_q    <= '0;
      x_clamp_q  <= '0;
      x_jump_q   <= 1'b0;
      player_x_q <= X_INIT_V;
      jump_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_raw_q    <= x_raw_d;
      x_clamp_q  <= x_clamp_d;
      x_jump_q   <= x_jump_d;
      player_x_q <= player_x_d;
      jump_q     <= jump_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      pending_q  <= pending_d;
    end
  end

  assign out_valid = valid_q;
  assign player_x  = player_x_q;
  assign jump_req  = jump_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mouse_sample_ctrl.sv
// Self-checking bench for mouse_sample_ctrl against a frame-level behavioural model.
module tb_mouse_sample_ctrl;

  localparam int X_MIN    = 0;
  localparam int X_MAX    = 400;
  localparam int X_INIT   = 100;
  localparam int MAX_STEP = 16;
  localparam int DEB      = 4;
  localparam int LAT      = 4;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [11:0] player_x;
  logic        jump_req;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  int m_x = X_INIT;
  bit m_pend = 1'b0;

  mouse_sample_ctrl #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .X_INIT(X_INIT), .MAX_STEP(MAX_STEP), .DEB_CYCLES(DEB)
  ) dut (
    .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .out_ready(out_ready), .out_valid(out_valid),
    .player_x(player_x), .jump_req(jump_req), .overrun(overrun)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Target x after one accepted frame: clamp to the court, then move at most MAX_STEP.
  function automatic int model_next(input int cur, input int raw);
    int c;
    c = (raw < X_MIN) ? X_MIN : ((raw > X_MAX) ? X_MAX : raw);
    if (c - cur > MAX_STEP) return cur + MAX_STEP;
    if (c - cur < -MAX_STEP) return cur - MAX_STEP;
    return c;
  endfunction

  // Hold the button for len cycles, then release long enough for the level to settle.
  task automatic press(input int len);
    mouse_left = 1'b1;
    repeat (len) step();
    mouse_left = 1'b0;
    repeat (10) step();
    if (len >= DEB) m_pend = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Drive one frame; report latency, presented sample, and whether it stayed stable and cleared.
  task automatic run_frame(input logic [11:0] xp, input int hold, output int lat,
                           output logic [11:0] px, output logic jr, output bit ok);
    ok = 1'b1;
    mouse_xpos = xp;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    wait_valid(lat);
    px = player_x;
    jr = jump_req;
    repeat (hold) begin
      step();
      if (out_valid !== 1'b1 || player_x !== px || jump_req !== jr || overrun !== 1'b0) ok = 1'b0;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || jump_req !== 1'b0) ok = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    m_x = X_INIT;
    m_pend = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || player_x !== 12'(X_INIT) || jump_req !== 1'b0 || overrun !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d: valid=%b x=%0d jump=%b ovr=%b, need 0 %0d 0 0",
                 i, out_valid, player_x, jump_req, overrun, X_INIT);
      end
    end
  endtask

  task automatic test_basic();
    int lat; logic [11:0] px; logic jr; bit ok; int exp;
    exp = model_next(m_x, 110);
    run_frame(12'd110, 0, lat, px, jr, ok);
    checks++;
    if (lat != LAT || px !== 12'(exp) || jr !== 1'b0 || !ok) begin
      failures++;
      $display("FAIL basic: lat=%0d x=%0d jump=%b ok=%0d, need lat=%0d x=%0d jump=0 ok=1",
               lat, px, jr, ok, LAT, exp);
    end
    m_x = exp;
  endtask

  task automatic test_saturate();
    int lat; logic [11:0] px; logic jr; bit ok; int exp;
    for (int i = 0; i < 22; i++) begin
      exp = model_next(m_x, 4000);
      run_frame(12'd4000, i % 2, lat, px, jr, ok);
      checks++;
      if (lat != LAT || px !== 12'(exp) || px > 12'(X_MAX) || !ok) begin
        failures++;
        $display("FAIL saturate i=%0d: lat=%0d x=%0d ok=%0d, need lat=%0d x=%0d", i, lat, px, ok, LAT, exp);
      end
      m_x = exp;
    end
    checks++;
    if (player_x !== 12'(X_MAX)) begin
      failures++;
      $display("FAIL saturate_end: x=%0d need %0d", player_x, X_MAX);
    end
  endtask

  task automatic test_overrun();
    int lat; int exp;
    exp = model_next(m_x, 250);
    mouse_xpos = 12'd250;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    wait_valid(lat);
    repeat (3) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pulse: ovr=%b need 1", overrun);
    end
    step();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_width: ovr=%b need 0", overrun);
    end
    repeat (5) step();
    checks++;
    if (out_valid !== 1'b1 || player_x !== 12'(exp) || lat != LAT) begin
      failures++;
      $display("FAIL overrun_hold: valid=%b x=%0d lat=%0d, need 1 %0d %0d", out_valid, player_x, lat, exp, LAT);
    end
    m_x = exp;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || player_x !== 12'(m_x)) begin
        failures++;
        $display("FAIL overrun_no_extra cyc=%0d: valid=%b x=%0d, need 0 %0d", i, out_valid, player_x, m_x);
      end
    end
    // Tick landing on the acceptance cycle is dropped too.
    exp = model_next(m_x, 30);
    mouse_xpos = 12'd30;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    wait_valid(lat);
    frame_tick = 1'b1;
    out_ready = 1'b1;
    step();
    frame_tick = 1'b0;
    out_ready = 1'b0;
    m_x = exp;
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b0 || player_x !== 12'(exp)) begin
      failures++;
      $display("FAIL overrun_accept: ovr=%b valid=%b x=%0d, need 1 0 %0d", overrun, out_valid, player_x, exp);
    end
    repeat (10) step();
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_accept_idle: valid=%b ovr=%b, need 0 0", out_valid, overrun);
    end
  endtask

  task automatic test_debounce();
    int lat; logic [11:0] px; logic jr; bit ok; int exp; bit ej;
    int lens[5] = '{2, 5, 0, 3, 4};
    for (int i = 0; i < 5; i++) begin
      if (lens[i] > 0) press(lens[i]);
      ej = m_pend;
      exp = model_next(m_x, 200 + i);
      run_frame(12'(200 + i), 1, lat, px, jr, ok);
      checks++;
      if (jr !== ej || px !== 12'(exp) || !ok) begin
        failures++;
        $display("FAIL debounce len=%0d: jump=%b x=%0d ok=%0d, need jump=%b x=%0d", lens[i], jr, px, ok, ej, exp);
      end
      m_x = exp;
      if (ej) m_pend = 1'b0;
    end
    // Two clicks before capture collapse into one jump.
    press(5);
    press(6);
    for (int i = 0; i < 2; i++) begin
      ej = m_pend;
      exp = model_next(m_x, 150);
      run_frame(12'd150, 0, lat, px, jr, ok);
      checks++;
      if (jr !== ej || px !== 12'(exp) || !ok) begin
        failures++;
        $display("FAIL debounce_collapse i=%0d: jump=%b x=%0d, need jump=%b x=%0d", i, jr, px, ej, exp);
      end
      m_x = exp;
      if (ej) m_pend = 1'b0;
    end
    // A click while a sample is presented goes into the following sample.
    ej = m_pend;
    exp = model_next(m_x, 160);
    mouse_xpos = 12'd160;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    wait_valid(lat);
    jr = jump_req;
    press(5);
    checks++;
    if (jr !== ej || jump_req !== ej || out_valid !== 1'b1 || player_x !== 12'(exp)) begin
      failures++;
      $display("FAIL debounce_present: jump=%b/%b valid=%b x=%0d, need jump=%b valid=1 x=%0d",
               jr, jump_req, out_valid, player_x, ej, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    m_x = exp;
    ej = m_pend;
    exp = model_next(m_x, 160);
    run_frame(12'd160, 0, lat, px, jr, ok);
    checks++;
    if (jr !== ej || jr !== 1'b1 || !ok) begin
      failures++;
      $display("FAIL debounce_next: jump=%b ok=%0d, need jump=1", jr, ok);
    end
    m_x = exp;
    m_pend = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [11:0] px; logic jr; bit ok; int exp;
    press(5);
    mouse_xpos = 12'd300;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_x = X_INIT;
    m_pend = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || player_x !== 12'(X_INIT) || jump_req !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d: valid=%b x=%0d jump=%b, need 0 %0d 0",
                 i, out_valid, player_x, jump_req, X_INIT);
      end
    end
    exp = model_next(m_x, 300);
    run_frame(12'd300, 0, lat, px, jr, ok);
    checks++;
    if (lat != LAT || px !== 12'(exp) || jr !== 1'b0 || !ok) begin
      failures++;
      $display("FAIL reset_mid_frame: lat=%0d x=%0d jump=%b, need %0d %0d 0", lat, px, jr, LAT, exp);
    end
    m_x = exp;
  endtask

  task automatic test_random();
    int lat; logic [11:0] px; logic jr; bit ok; int exp; bit ej; int xp; int plen;
    for (int i = 0; i < 30; i++) begin
      plen = int'($urandom_range(0, 7));
      if (plen > 0) press(plen);
      xp = int'($urandom_range(0, 4095));
      if (i % 5 == 0) xp = int'($urandom_range(0, 500));
      ej = m_pend;
      exp = model_next(m_x, xp);
      run_frame(12'(xp), int'($urandom_range(0, 3)), lat, px, jr, ok);
      checks++;
      if (lat != LAT || px !== 12'(exp) || jr !== ej || !ok) begin
        failures++;
        $display("FAIL random i=%0d xp=%0d: lat=%0d x=%0d jump=%b ok=%0d, need lat=%0d x=%0d jump=%b",
                 i, xp, lat, px, jr, ok, LAT, exp, ej);
      end
      m_x = exp;
      if (ej) m_pend = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_overrun();
    test_debounce();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
